core_seq_ctrl: RTL

- Multi-cycle sequencer for the single-issue RV64 core.
- Drives instruction fetch over the imem handshake and latches the instruction register (IR) that feeds the combinational decoder.
- Consumes the decoder's inst_type and the execute-side flags, then steps the datapath through memory access and register writeback.
- Owns the PC and instret and halts the core on ebreak (TYPE_N).

---
 rtl/core_seq_ctrl_pkg.sv | 31 +++
 rtl/seq_timeout_cnt.sv | 27 ++
 rtl/core_seq_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle core sequencer and its decoder.
// Instruction type codes must match the decoder's inst_type encoding.
package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_IWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] TYPE_I   = 3'd0;
  localparam logic [2:0] TYPE_U   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_J   = 3'd3;
  localparam logic [2:0] TYPE_R   = 3'd4;
  localparam logic [2:0] TYPE_B   = 3'd5;
  localparam logic [2:0] TYPE_N   = 3'd6;
  localparam logic [2:0] TYPE_ILL = 3'b111;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  // S and B formats carry no rd field; everything else with an rd writes back.
  function automatic logic type_writes_rd(input logic [2:0] t);
    return (t == TYPE_I) || (t == TYPE_U) || (t == TYPE_J) || (t == TYPE_R);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Fetch-wait counter: cleared while fetching, counts stalled IWAIT cycles.
// expired flags the stalled cycle whose increment would reach LIMIT.
module seq_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: fetch over imem, decode, execute, memory, writeback.
// Owns pc, instret and the instruction register; halts on ebreak or error.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | imem_req high, waiting for imem_ready
// IWAIT    | waiting for imem_rvalid, timeout counter runs
// DECODE   | ir stable, decoder settles (1 cycle)
// EXEC     | sample inst_type / is_load / is_store (1 cycle)
// MEM      | dmem_req high until dmem_done
// WB       | rf write strobe, pc and instret update (1 cycle)
// HALT     | absorbing until reset; err holds the cause
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET      = PC_RESET_DEFAULT,
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter logic [63:0] INSTRET_RESET = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic [2:0]  inst_type,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [63:0] next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_done,
  output logic        rf_wen,
  output logic [63:0] pc,
  output logic [63:0] instret,
  output logic        halted,
  output logic        err
);

  state_t      state_q, state_d;
  logic [63:0] pc_q, instret_q;
  logic [31:0] ir_q;
  logic        err_q, set_err;
  logic        store_q, wen_q;
  logic        tmo_expired;

  seq_timeout_cnt #(.LIMIT(FETCH_TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_FETCH),
    .en      ((state_q == S_IWAIT) && !imem_rvalid),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      instret_q <= INSTRET_RESET;
      ir_q      <= 32'd0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_err) err_q <= 1'b1;
      if ((state_q == S_IWAIT) && imem_rvalid) ir_q <= imem_rdata;
      if (state_q == S_EXEC) begin
        store_q <= is_store;
        wen_q   <= type_writes_rd(inst_type) || is_load;
      end
      if (state_q == S_WB) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    unique case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_IWAIT;
      S_IWAIT: begin
        // rvalid takes priority over a timeout landing on the same edge
        if (imem_rvalid) begin
          state_d = S_DECODE;
        end else if (tmo_expired) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (inst_type == TYPE_N) begin
          state_d = S_HALT;
        end else if ((inst_type == TYPE_ILL) || (is_load && is_store)) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM:    if (dmem_done) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Strobes are gated with rst so they fall the moment reset asserts.
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM) || (state_q == S_WB)) && !rst;
  assign dmem_req  = (state_q == S_MEM) && !rst;
  assign dmem_we   = (state_q == S_MEM) && store_q && !rst;
  assign rf_wen    = (state_q == S_WB) && wen_q && !rst;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;

endmodule
